// File: rtl/adjust_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adjust_pkg
// Description : Shared FSM state encoding, direction constants and helpers
//               for the adjust_pulse_gen button-to-step-pulse block.
// Revision    : 1.0 - initial release
// ============================================================================
package adjust_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DEBOUNCE = 3'd1;
    localparam logic [2:0] ST_HOLD     = 3'd2;
    localparam logic [2:0] ST_REPEAT   = 3'd3;
    localparam logic [2:0] ST_RELEASE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        DEBOUNCE = ST_DEBOUNCE,
        HOLD     = ST_HOLD,
        REPEAT   = ST_REPEAT,
        RELEASE  = ST_RELEASE
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync.sv
`default_nettype none
// ============================================================================
// Module      : btn_sync
// Description : Two-flop synchronizer bringing a raw push-button level into
//               the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
        end
    end

    assign sync_out = r_sync;

endmodule
`default_nettype wire

// File: rtl/adjust_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : adjust_pulse_gen
// Description : Debounces up/down buttons into one-clk step pulses for an
//               up/down counter. Auto-repeat while held is built only when
//               ADJUST_PULSE_AUTOREPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module adjust_pulse_gen
    import adjust_pkg::*;
#(
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_ms,
    input  logic btn_up,
    input  logic btn_down,
    output logic en,
    output logic upDown,
    output logic busy
);

    localparam int c_CNT_MAX = max3(DEBOUNCE_MS, REPEAT_DELAY_MS, REPEAT_RATE_MS);
    localparam int c_CNT_W   = ($clog2(c_CNT_MAX + 1) < 1) ? 1 : $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_SAT = c_CNT_W'(c_CNT_MAX);
    localparam logic [c_CNT_W-1:0] c_DEB     = c_CNT_W'(DEBOUNCE_MS);
`ifdef ADJUST_PULSE_AUTOREPEAT_EN
    localparam logic [c_CNT_W-1:0] c_DLY     = c_CNT_W'(REPEAT_DELAY_MS);
    localparam logic [c_CNT_W-1:0] c_RATE    = c_CNT_W'(REPEAT_RATE_MS);
`endif

    logic w_up_s;
    logic w_down_s;

    btn_sync u_sync_up (
        .clk      (clk),
        .rst      (rst),
        .async_in (btn_up),
        .sync_out (w_up_s)
    );

    btn_sync u_sync_down (
        .clk      (clk),
        .rst      (rst),
        .async_in (btn_down),
        .sync_out (w_down_s)
    );

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               r_dir;
    logic               w_dir_nxt;
    logic               r_en;
    logic               w_en_nxt;

    logic w_press;
    logic w_press_dir;
    logic w_same;

    // Both buttons down cancels out and reads as no press at all.
    assign w_press     = w_up_s ^ w_down_s;
    assign w_press_dir = w_down_s ? DIR_DOWN : DIR_UP;
    assign w_same      = w_press && (w_press_dir == r_dir);
    assign w_cnt_inc   = (r_cnt == c_CNT_SAT) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dir   <= DIR_UP;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_en    <= w_en_nxt;
        end
    end

    // Input-driven transitions are tested before tick_ms so a coincident tick is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_en_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_press) begin
                    w_dir_nxt   = w_press_dir;
                    w_cnt_nxt   = '0;
                    w_state_nxt = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!w_same) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (tick_ms) begin
                    if (w_cnt_inc == c_DEB) begin
                        w_en_nxt    = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = HOLD;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
            end
            HOLD: begin
                if (!w_same) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RELEASE;
                end
`ifdef ADJUST_PULSE_AUTOREPEAT_EN
                else if (tick_ms) begin
                    if (w_cnt_inc == c_DLY) begin
                        w_en_nxt    = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = REPEAT;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
`endif
            end
`ifdef ADJUST_PULSE_AUTOREPEAT_EN
            REPEAT: begin
                if (!w_same) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RELEASE;
                end else if (tick_ms) begin
                    if (w_cnt_inc == c_RATE) begin
                        w_en_nxt  = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
`endif
            RELEASE: begin
                if (w_press) begin
                    w_cnt_nxt = '0;
                end else if (tick_ms) begin
                    if (w_cnt_inc == c_DEB) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign en     = r_en;
    assign upDown = r_dir;
    assign busy   = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adjust_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_adjust_pulse_gen
// Description : Directed self-checking bench for adjust_pulse_gen with
//               DEBOUNCE_MS=2, REPEAT_DELAY_MS=5, REPEAT_RATE_MS=2, tick every
//               4 clk. Expectations follow ADJUST_PULSE_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adjust_pulse_gen;

`ifdef ADJUST_PULSE_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic tick_ms;
    logic btn_up;
    logic btn_down;
    logic en;
    logic upDown;
    logic busy;

    int vectors     = 0;
    int miscompares = 0;

    int   tick_cnt  = 0;
    int   n_pulses  = 0;
    int   n_consec  = 0;
    logic prev_en   = 1'b0;
    int   pulse_tick[$];
    logic pulse_dir[$];

    adjust_pulse_gen #(
        .DEBOUNCE_MS     (2),
        .REPEAT_DELAY_MS (5),
        .REPEAT_RATE_MS  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_ms  (tick_ms),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .en       (en),
        .upDown   (upDown),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        tick_ms = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 tick_ms = 1'b1;
            @(posedge clk);
            #1 tick_ms = 1'b0;
        end
    end

    // Pulse recorder, sampled on the falling edge.
    always @(negedge clk) begin
        if (tick_ms) tick_cnt++;
        if (en) begin
            n_pulses++;
            pulse_tick.push_back(tick_cnt);
            pulse_dir.push_back(upDown);
            if (prev_en) n_consec++;
        end
        prev_en = en;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        n_pulses = 0;
        n_consec = 0;
        pulse_tick.delete();
        pulse_dir.delete();
    endtask

    // Stops just after a falling edge on which tick_ms is high.
    task automatic align();
        int guard;
        guard = 0;
        do begin
            wait_clks(1);
            guard++;
        end while (!tick_ms && guard < 10);
        vectors++;
        if (!tick_ms) begin
            miscompares++;
            $display("FAIL align: tick_ms not seen within %0d clk", guard);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
        wait_clks(3);
        vectors++; if (en !== 1'b0)     begin miscompares++; $display("FAIL reset_en: got %b want 0", en); end
        vectors++; if (busy !== 1'b0)   begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (upDown !== 1'b0) begin miscompares++; $display("FAIL reset_updown: got %b want 0", upDown); end
        rst = 1'b0;
        wait_clks(4);
        vectors++; if (busy !== 1'b0)   begin miscompares++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_press();
        clear_mon();
        align();
        btn_up = 1'b1;
        wait_clks(12);
        btn_up = 1'b0;
        wait_clks(6);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_release_busy: got %b want 1", busy); end
        wait_clks(6);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_idle_busy: got %b want 0", busy); end
        vectors++; if (n_pulses !== 1) begin miscompares++; $display("FAIL single_pulses: got %0d want 1", n_pulses); end
        if (n_pulses > 0) begin
            vectors++; if (pulse_dir[0] !== 1'b0) begin miscompares++; $display("FAIL single_dir: got %b want 0", pulse_dir[0]); end
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        align();
        btn_down = 1'b1;
        wait_clks(3);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL glitch_debounce_busy: got %b want 1", busy); end
        wait_clks(1);
        btn_down = 1'b0;
        wait_clks(8);
        vectors++; if (n_pulses !== 0) begin miscompares++; $display("FAIL glitch_pulses: got %0d want 0", n_pulses); end
        vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL glitch_busy: got %b want 0", busy); end
    endtask

    task automatic test_autorepeat();
        int t0;
        int exp_n;
        exp_n = AUTOREP ? 4 : 1;
        clear_mon();
        align();
        t0 = tick_cnt;
        btn_down = 1'b1;
        wait_clks(48);
        btn_down = 1'b0;
        wait_clks(12);
        vectors++; if (n_pulses !== exp_n) begin miscompares++; $display("FAIL repeat_pulses: got %0d want %0d", n_pulses, exp_n); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL repeat_idle_busy: got %b want 0", busy); end
        vectors++; if (n_consec !== 0) begin miscompares++; $display("FAIL repeat_consec_en: got %0d want 0", n_consec); end
        foreach (pulse_dir[i]) begin
            vectors++;
            if (pulse_dir[i] !== 1'b1) begin miscompares++; $display("FAIL repeat_dir[%0d]: got %b want 1", i, pulse_dir[i]); end
        end
        if (n_pulses >= 1) begin
            vectors++;
            if (pulse_tick[0] - t0 !== 2) begin miscompares++; $display("FAIL repeat_first_gap: got %0d want 2", pulse_tick[0] - t0); end
        end
        if (AUTOREP && n_pulses == 4) begin
            vectors++; if (pulse_tick[1] - pulse_tick[0] !== 5) begin miscompares++; $display("FAIL repeat_delay: got %0d want 5", pulse_tick[1] - pulse_tick[0]); end
            vectors++; if (pulse_tick[2] - pulse_tick[1] !== 2) begin miscompares++; $display("FAIL repeat_rate1: got %0d want 2", pulse_tick[2] - pulse_tick[1]); end
            vectors++; if (pulse_tick[3] - pulse_tick[2] !== 2) begin miscompares++; $display("FAIL repeat_rate2: got %0d want 2", pulse_tick[3] - pulse_tick[2]); end
        end
    endtask

    task automatic test_both_buttons();
        int exp_n;
        exp_n = AUTOREP ? 2 : 1;
        clear_mon();
        align();
        btn_up = 1'b1;
        wait_clks(32);
        btn_down = 1'b1;
        wait_clks(4);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL both_release_busy: got %b want 1", busy); end
        btn_up = 1'b0;
        btn_down = 1'b0;
        wait_clks(12);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL both_idle_busy: got %b want 0", busy); end
        vectors++; if (n_pulses !== exp_n) begin miscompares++; $display("FAIL both_pulses: got %0d want %0d", n_pulses, exp_n); end
    endtask

    task automatic test_reset_in_hold();
        clear_mon();
        align();
        btn_up = 1'b1;
        wait_clks(12);
        vectors++; if (n_pulses !== 1) begin miscompares++; $display("FAIL hold_first_pulse: got %0d want 1", n_pulses); end
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        vectors++; if (en !== 1'b0)   begin miscompares++; $display("FAIL hold_rst_en: got %b want 0", en); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL hold_rst_busy: got %b want 0", busy); end
        clear_mon();
        wait_clks(6);
        vectors++; if (n_pulses !== 0) begin miscompares++; $display("FAIL hold_redebounce_early: got %0d want 0", n_pulses); end
        vectors++; if (busy !== 1'b1)  begin miscompares++; $display("FAIL hold_redebounce_busy: got %b want 1", busy); end
        wait_clks(4);
        vectors++; if (n_pulses !== 1) begin miscompares++; $display("FAIL hold_redebounce_pulse: got %0d want 1", n_pulses); end
        if (n_pulses > 0) begin
            vectors++; if (pulse_dir[0] !== 1'b0) begin miscompares++; $display("FAIL hold_redebounce_dir: got %b want 0", pulse_dir[0]); end
        end
        btn_up = 1'b0;
        wait_clks(24);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL hold_final_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_autorepeat();
        test_both_buttons();
        test_reset_in_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adjust_pulse_gen.md
ADJUST_PULSE_GEN -- requirements
Module: adjust_pulse_gen

Interface
REQ-001 Parameter DEBOUNCE_MS, default 20, number of consecutive tick_ms strobes a button level must hold stable to be accepted.
REQ-002 Parameter REPEAT_DELAY_MS, default 500, number of tick_ms strobes from the first pulse to the first auto-repeat pulse.
REQ-003 Parameter REPEAT_RATE_MS, default 100, number of tick_ms strobes between successive auto-repeat pulses.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 tick_ms  input  1  one-clk-wide 1 ms timebase strobe, synchronous to clk.
REQ-007 btn_up  input  1  raw asynchronous "increment" push button, active-high.
REQ-008 btn_down  input  1  raw asynchronous "decrement" push button, active-high.
REQ-009 en  output  1  one-clk step pulse to the up/down mod counter's enable input.
REQ-010 upDown  output  1  step direction, 0 = up, 1 = down; valid whenever en = 1.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 Each button SHALL pass through a two-flop synchronizer before use; all timing below is from the synchronized level.
REQ-013 "Press" SHALL mean exactly one synchronized button high; both high or both low SHALL mean "no press".
REQ-014 FSM states SHALL be IDLE, DEBOUNCE, HOLD, REPEAT and RELEASE.
REQ-015 IDLE: on a press, latch direction (up = 0, down = 1), clear the ms counter, go to DEBOUNCE.
REQ-016 DEBOUNCE: count tick_ms while the latched press persists; if it changes or drops, return to IDLE; on reaching DEBOUNCE_MS, assert en for one clk on the following cycle and go to HOLD.
REQ-017 HOLD: count tick_ms up to REPEAT_DELAY_MS, then pulse en and go to REPEAT; REPEAT: pulse en every REPEAT_RATE_MS tick_ms strobes.
REQ-018 In HOLD or REPEAT, any loss of the latched press, including the opposite button joining, SHALL go to RELEASE with no further pulse.
REQ-019 RELEASE: return to IDLE only after DEBOUNCE_MS consecutive tick_ms strobes with no press; any press during the count restarts it.
REQ-020 en SHALL be a registered output, never high on two consecutive clks; upDown SHALL hold the latched direction from DEBOUNCE until IDLE.
REQ-021 The ms counter SHALL be wide enough for the largest of the three parameters; it saturates and never wraps.
REQ-022 tick_ms coinciding with a state-changing input edge SHALL be ignored; the transition takes priority.

Reset
REQ-023 With rst high at a clk edge: state = IDLE, en = 0, upDown = 0, busy = 0, counter and synchronizers cleared.
REQ-024 Reset mid-hold SHALL suppress any pending pulse; a still-held button after reset needs a full debounce again.

Configuration
REQ-025 Macro ADJUST_PULSE_AUTOREPEAT_EN defined: HOLD/REPEAT behave as in REQ-017.
REQ-026 Macro ADJUST_PULSE_AUTOREPEAT_EN undefined: HOLD waits for release and never pulses; exactly one en per press; REPEAT is not built; REPEAT_* parameters are unused.

Structure
REQ-027 Package adjust_pkg SHALL hold the FSM state enum and the constants DIR_UP = 0 and DIR_DOWN = 1.
REQ-028 The two-flop synchronizer SHALL be a sub-module btn_sync, instantiated once per button.

Verification (DEBOUNCE_MS = 2, REPEAT_DELAY_MS = 5, REPEAT_RATE_MS = 2, tick_ms every 4 clk)
REQ-029 btn_up held for 3 ticks, then released -> exactly one en pulse with upDown = 0, then busy drops after 2 idle ticks.
REQ-030 btn_down glitch of 1 tick -> no en pulse and return to IDLE.
REQ-031 btn_down held for 12 ticks with autorepeat on -> pulses at debounce + 0, 5, 7 and 9 ticks, each with upDown = 1 -> 4 pulses in total.
REQ-032 btn_up held, then btn_down added mid-REPEAT -> no further pulses, RELEASE, then IDLE 2 ticks after both are released.
REQ-033 rst asserted during HOLD -> en = 0 and state = IDLE on the next clk; held button re-debounces before the next pulse.
REQ-034 Same as REQ-031 with ADJUST_PULSE_AUTOREPEAT_EN undefined -> exactly 1 pulse.
